pwm_multi_gen: RTL and testbench

- Multi-channel PWM generator, the parametrised successor to the single-channel 8-bit fixed-period PWM block.
- One shared period counter drives CHANNELS independent duty comparators.
- Adds a programmable period, edge-aligned and centre-aligned modes, and glitch-free shadow-register updates applied only at period boundaries.
- Sits between a control/register interface and motor, LED or power-stage pins.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_channel_cmp.sv | 53 +++++
 rtl/pwm_multi_gen.sv | 144 ++++++++++++++
 tb/tb_pwm_multi_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// - MODE_EDGE / MODE_CENTER : encodings of the mode input and the mode registers
// - dir_e                   : direction of the shared counter (DIR_UP / DIR_DOWN)
// - RST_PERIOD / RST_DUTY   : reset values for the period/duty registers, sliced to WIDTH bits
//                             by the users (WIDTH must not exceed MaxWidth)
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned MaxWidth = 32;

  // All ones: the default period is the longest one the counter can express.
  localparam logic [MaxWidth-1:0] RST_PERIOD = '1;
  localparam logic [MaxWidth-1:0] RST_DUTY   = '0;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: staging and active duty registers plus the registered comparator.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - asynchronous active-low reset
//   enable_i  - 0 forces the output low
//   load_i    - strobe capturing duty_i into the staging register
//   update_i  - period boundary with a pending or simultaneous load; refreshes the active duty
//   duty_i    - new duty value (high-time compare value)
//   cnt_i     - shared period counter
//   pwm_o     - registered PWM output, one cycle behind cnt_i
module pwm_channel_cmp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic             update_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);
  import pwm_pkg::*;

  logic [WIDTH-1:0] stg_duty_q, stg_duty_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    stg_duty_d = load_i ? duty_i : stg_duty_q;
    act_duty_d = act_duty_q;
    if (update_i) begin
      // A load coinciding with the boundary bypasses staging.
      act_duty_d = load_i ? duty_i : stg_duty_q;
    end
    pwm_d = enable_i & (cnt_i < act_duty_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_duty_q <= RST_DUTY[WIDTH-1:0];
      act_duty_q <= RST_DUTY[WIDTH-1:0];
      pwm_q      <= 1'b0;
    end else begin
      stg_duty_q <= stg_duty_d;
      act_duty_q <= act_duty_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, CHANNELS duty comparators.
// Supports a programmable period, edge- and centre-aligned counting and shadowed
// (staging -> active) updates that only take effect at period boundaries.
// Ports:
//   clk_i         - clock, rising edge
//   rst_ni        - asynchronous active-low reset
//   enable_i      - 1 = run; 0 = hold counter at 0 and force outputs low
//   load_i        - strobe capturing period_i, duty_i and mode_i into staging
//   period_i      - terminal count (edge mode cycle = period+1, centre mode cycle = 2*period)
//   duty_i        - packed duties, channel i at [i*WIDTH +: WIDTH]
//   mode_i        - 0 = edge-aligned, 1 = centre-aligned
//   pwm_out_o     - registered PWM outputs
//   period_tick_o - registered one-cycle pulse in the cycle where a new period starts at cnt 0
module pwm_multi_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      mode_i,
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic                      period_tick_o
);
  import pwm_pkg::*;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] stg_period_q, stg_period_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic             stg_mode_q, stg_mode_d;
  logic             act_mode_q, act_mode_d;
  logic             tick_q, tick_d;

  logic             bnd;
  logic             update;

  // Boundary: last cycle of the current period, or every cycle while disabled.
  always_comb begin
    if (!enable_i) begin
      bnd = 1'b1;
    end else if (act_mode_q == MODE_EDGE || act_period_q == '0) begin
      bnd = (cnt_q == act_period_q);
    end else begin
      // With a centre period of 1 the peak is also the last count, so the boundary
      // is taken at cnt 1 on the way up to keep the 2-cycle period.
      bnd = (cnt_q == One) && (dir_q == DIR_DOWN || act_period_q == One);
    end
  end

  assign update = bnd & (pending_q | load_i);

  always_comb begin
    stg_period_d = stg_period_q;
    stg_mode_d   = stg_mode_q;
    act_period_d = act_period_q;
    act_mode_d   = act_mode_q;
    pending_d    = pending_q;

    if (load_i) begin
      stg_period_d = period_i;
      stg_mode_d   = mode_i;
    end

    if (update) begin
      act_period_d = load_i ? period_i : stg_period_q;
      act_mode_d   = load_i ? mode_i : stg_mode_q;
    end

    // At a boundary any pending or simultaneous load has just been applied.
    if (bnd) begin
      pending_d = 1'b0;
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (bnd) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (act_mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + One;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == act_period_q) begin
        cnt_d = act_period_q - One;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else begin
      cnt_d = cnt_q - One;
    end
    tick_d = bnd & enable_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      pending_q    <= 1'b0;
      stg_period_q <= RST_PERIOD[WIDTH-1:0];
      act_period_q <= RST_PERIOD[WIDTH-1:0];
      stg_mode_q   <= MODE_EDGE;
      act_mode_q   <= MODE_EDGE;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      stg_period_q <= stg_period_d;
      act_period_q <= act_period_d;
      stg_mode_q   <= stg_mode_d;
      act_mode_q   <= act_mode_d;
      tick_q       <= tick_d;
    end
  end

  assign period_tick_o = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel_cmp #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .enable_i(enable_i),
      .load_i  (load_i),
      .update_i(update),
      .duty_i  (duty_i[i*WIDTH +: WIDTH]),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm_out_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
module tb_pwm_multi_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic [7:0]  per;
  logic [31:0] dty;
  logic        md;
  logic [3:0]  pwm;
  logic        tick;

  int tests_run;
  int tests_failed;

  // Reference model: phase index within the period, cnt derived from the phase.
  int unsigned m_ph;
  logic [7:0]  m_per, s_per;
  logic        m_mode, s_mode, m_pend;
  logic [7:0]  m_duty[4];
  logic [7:0]  s_duty[4];
  logic [4:0]  sb_q[$];

  logic [3:0]  obs_pwm;
  logic        obs_tick;

  pwm_multi_gen #(
    .WIDTH   (8),
    .CHANNELS(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (en),
    .load_i       (ld),
    .period_i     (per),
    .duty_i       (dty),
    .mode_i       (md),
    .pwm_out_o    (pwm),
    .period_tick_o(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph   = 0;
    m_per  = 8'hff;
    s_per  = 8'hff;
    m_mode = 1'b0;
    s_mode = 1'b0;
    m_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = 8'd0;
      s_duty[i] = 8'd0;
    end
    sb_q.delete();
  endtask

  function automatic int unsigned m_len();
    int unsigned p;
    p = m_per;
    if (m_mode == 1'b0 || p == 0) return p + 1;
    return 2 * p;
  endfunction

  function automatic int unsigned m_cnt();
    int unsigned p;
    p = m_per;
    if (m_mode == 1'b0 || m_ph <= p) return m_ph;
    return 2 * p - m_ph;
  endfunction

  // One clock: predict outputs from the model, advance it, then compare after the edge.
  task automatic tick_cycle();
    int unsigned c;
    logic        bnd;
    logic [3:0]  ep;
    logic [4:0]  exp_v;
    logic [4:0]  got;
    c   = m_cnt();
    bnd = !en || (m_ph == m_len() - 1);
    for (int i = 0; i < 4; i++) ep[i] = en && (c < m_duty[i]);
    sb_q.push_back({ep, bnd && en});
    if (bnd) begin
      m_ph = 0;
      if (ld) begin
        m_per  = per;
        m_mode = md;
        for (int i = 0; i < 4; i++) m_duty[i] = dty[i*8 +: 8];
      end else if (m_pend) begin
        m_per  = s_per;
        m_mode = s_mode;
        for (int i = 0; i < 4; i++) m_duty[i] = s_duty[i];
      end
      m_pend = 1'b0;
    end else begin
      m_ph = m_ph + 1;
      if (ld) m_pend = 1'b1;
    end
    if (ld) begin
      s_per  = per;
      s_mode = md;
      for (int i = 0; i < 4; i++) s_duty[i] = dty[i*8 +: 8];
    end
    @(posedge clk);
    #1;
    got   = {pwm, tick};
    exp_v = sb_q.pop_front();
    tests_run++;
    if (got !== exp_v) begin
      tests_failed++;
      $display("FAIL cycle_outputs t=%0t: pwm/tick got %b/%b, want %b/%b",
               $time, got[4:1], got[0], exp_v[4:1], exp_v[0]);
    end
    obs_pwm  = pwm;
    obs_tick = tick;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic do_load(input logic [7:0] p, input logic [31:0] d, input logic m);
    per = p;
    dty = d;
    md  = m;
    ld  = 1'b1;
    tick_cycle();
    ld  = 1'b0;
  endtask

  // Cycles until a period_tick is seen; exp_n is the required count.
  task automatic wait_tick(input string name, input int exp_n);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 600) begin
      tick_cycle();
      n++;
      if (obs_tick) seen = 1;
    end
    tests_run++;
    if (!seen || n != exp_n) begin
      tests_failed++;
      $display("FAIL %s: tick after %0d cycles (seen=%0d), want %0d", name, n, seen, exp_n);
    end
  endtask

  // Called right after a new period starts: checks period length and per-channel high time.
  task automatic measure_period(input string name, input int exp_len,
                                input int e0, input int e1, input int e2, input int e3);
    int n;
    bit seen;
    int hi[4];
    int eh[4];
    bit bad;
    n     = 0;
    seen  = 0;
    eh[0] = e0;
    eh[1] = e1;
    eh[2] = e2;
    eh[3] = e3;
    for (int i = 0; i < 4; i++) hi[i] = 0;
    while (!seen && n < exp_len + 20) begin
      tick_cycle();
      n++;
      for (int i = 0; i < 4; i++) if (obs_pwm[i]) hi[i]++;
      if (obs_tick) seen = 1;
    end
    tests_run++;
    if (!seen || n != exp_len) begin
      tests_failed++;
      $display("FAIL %s_len: got %0d cycles (seen=%0d), want %0d", name, n, seen, exp_len);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (hi[i] != eh[i]) bad = 1;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL %s_high: ch0..3 got %0d %0d %0d %0d, want %0d %0d %0d %0d",
               name, hi[0], hi[1], hi[2], hi[3], eh[0], eh[1], eh[2], eh[3]);
    end
  endtask

  task automatic test_reset();
    #23;
    tests_run++;
    if ({pwm, tick} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: pwm/tick got %b/%b, want 0000/0", pwm, tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    measure_period("reset_first", 256, 0, 0, 0, 0);
    measure_period("reset_second", 256, 0, 0, 0, 0);
  endtask

  task automatic test_edge();
    do_load(8'd9, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    wait_tick("edge_switch", 255);
    measure_period("edge_a", 10, 0, 1, 5, 10);
    measure_period("edge_b", 10, 0, 1, 5, 10);
  endtask

  task automatic test_shadow();
    idle(3);
    do_load(8'd4, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    wait_tick("shadow_tail", 6);
    measure_period("shadow_new", 5, 0, 1, 5, 5);
    do_load(8'd9, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    wait_tick("shadow_back", 4);
    measure_period("shadow_p9", 10, 0, 1, 5, 10);
    idle(9);
    do_load(8'd4, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    tests_run++;
    if (obs_tick !== 1'b1) begin
      tests_failed++;
      $display("FAIL shadow_at_end: tick got %b, want 1", obs_tick);
    end
    measure_period("shadow_at_end_p5", 5, 0, 1, 5, 5);
  endtask

  task automatic test_centre();
    do_load(8'd4, {8'd0, 8'd0, 8'd5, 8'd2}, 1'b1);
    wait_tick("centre_switch", 4);
    // cnt runs 0,1,2,3,4,3,2,1: duty 2 is high at 0 and both 1s.
    measure_period("centre_a", 8, 3, 8, 0, 0);
    measure_period("centre_b", 8, 3, 8, 0, 0);
    do_load(8'd9, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    wait_tick("centre_to_edge", 7);
    measure_period("edge_again", 10, 0, 1, 5, 10);
  endtask

  task automatic test_enable();
    idle(4);
    en = 1'b0;
    tick_cycle();
    tests_run++;
    if (obs_pwm !== 4'b0 || obs_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable: pwm/tick got %b/%b, want 0000/0", obs_pwm, obs_tick);
    end
    do_load(8'd6, {8'd10, 8'd5, 8'd1, 8'd0}, 1'b0);
    idle(2);
    en = 1'b1;
    measure_period("reenable_first", 7, 0, 1, 5, 7);
    measure_period("reenable_second", 7, 0, 1, 5, 7);
  endtask

  task automatic test_async_reset();
    idle(2);
    do_load(8'd3, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b0);
    tick_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pwm, tick} !== 5'b0) begin
      tests_failed++;
      $display("FAIL async_reset: pwm/tick got %b/%b, want 0000/0", pwm, tick);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure_period("post_reset", 256, 0, 0, 0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    en           = 1'b1;
    ld           = 1'b0;
    per          = 8'd0;
    dty          = 32'd0;
    md           = 1'b0;
    obs_pwm      = 4'b0;
    obs_tick     = 1'b0;
    model_reset();
    test_reset();
    test_edge();
    test_shadow();
    test_centre();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
